ads131_sequencer: RTL and testbench

- Control sequencer for the ADS131A0x SPI path. Owns the ADC hardware reset, the power-up handshake and the register configuration.
- Afterwards it turns each DRDY falling edge into one data frame and delivers per-channel samples.
- Drives a frame-level SPI master (CS/SCLK/shift) through a request/ack/done handshake. Sits between the SPI master and downstream sample consumers.

---
 rtl/ads131_sequencer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ads131_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads131_sequencer.sv
// ads131_sequencer
// Sequencer for the ADS131A0x SPI path. It pulses the ADC hardware reset,
// polls for READY, writes and verifies the register configuration, then turns
// each DRDY falling edge into one frame and emits per-channel samples.
//
// Ports
//   system_clock, reset      : clock, synchronous active-high reset
//   adc_init                 : start/restart pulse (IDLE, RUN_WAIT, ERROR only)
//   adc_drdy_n               : asynchronous DRDY from the ADC, active-low
//   SPI_RESET                : ADC hardware reset, active-low
//   frame_req/cmd/ack        : frame request handshake to the SPI master
//   rx_word_valid/rx_word    : received 24-bit words in frame order
//   frame_done               : frame complete, CS released
//   sample_valid/ch/data     : one-cycle sample strobe with channel and value
//   adc_init_completed       : configuration verified, streaming
//   init_error/error_code    : sticky error, 1=READY timeout, 2=ack mismatch
//   overrun_cnt              : saturating count of dropped DRDY edges
//   state                    : FSM state encoding
//
// state    | meaning
// IDLE     | waiting for adc_init
// HWRST    | SPI_RESET low phase, then post-reset wait
// POLL     | NULL frames until READY status or poll limit
// CFG      | command list, each frame's status checks the previous command
// RUN_WAIT | streaming, waiting for a DRDY pulse
// RUN_READ | data frame in flight, samples emitted
// ERROR    | sticky error, waiting for adc_init
module ads131_sequencer #(
    parameter int         NUM_CH         = 4,
    parameter int         RST_LOW_CYC    = 50,
    parameter int         RST_WAIT_CYC   = 250000,
    parameter int         READY_POLL_MAX = 16,
    parameter logic [7:0] CLK1_VAL       = 8'h02,
    parameter logic [7:0] CLK2_VAL       = 8'h25,
    parameter logic [7:0] ADC_ENA_VAL    = 8'h0F
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        adc_init,
    input  logic        adc_drdy_n,
    output logic        SPI_RESET,
    output logic        frame_req,
    output logic [15:0] frame_cmd,
    input  logic        frame_ack,
    input  logic        rx_word_valid,
    input  logic [23:0] rx_word,
    input  logic        frame_done,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [23:0] sample_data,
    output logic        adc_init_completed,
    output logic        init_error,
    output logic [1:0]  error_code,
    output logic [7:0]  overrun_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HWRST    = 3'd1,
        POLL     = 3'd2,
        CFG      = 3'd3,
        RUN_WAIT = 3'd4,
        RUN_READ = 3'd5,
        ERROR    = 3'd6
    } state_t;

    localparam logic [2:0]  NCH        = 3'(NUM_CH);
    localparam logic [15:0] READY_WORD = 16'hFF00 | 16'(NUM_CH);
    localparam logic [7:0]  POLL_MAX   = 8'(READY_POLL_MAX);
    localparam logic [31:0] LOW_LD     = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0] WAIT_LD    = 32'(RST_WAIT_CYC - 1);

    function automatic logic [15:0] cfg_cmd(input logic [2:0] s);
        case (s)
            3'd0:    cfg_cmd = 16'h0655;
            3'd1:    cfg_cmd = {8'h4D, CLK1_VAL};
            3'd2:    cfg_cmd = {8'h4E, CLK2_VAL};
            3'd3:    cfg_cmd = {8'h4F, ADC_ENA_VAL};
            3'd4:    cfg_cmd = 16'h0033;
            3'd5:    cfg_cmd = 16'h0555;
            default: cfg_cmd = 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] cfg_ack(input logic [2:0] s);
        case (s)
            3'd0:    cfg_ack = 16'h0655;
            3'd1:    cfg_ack = {8'h2D, CLK1_VAL};
            3'd2:    cfg_ack = {8'h2E, CLK2_VAL};
            3'd3:    cfg_ack = {8'h2F, ADC_ENA_VAL};
            3'd4:    cfg_ack = 16'h0033;
            default: cfg_ack = 16'h0555;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  drdy_sync_q, drdy_sync_d;
    logic        spi_reset_q, spi_reset_d;
    logic [31:0] tmr_q, tmr_d;
    logic [7:0]  poll_q, poll_d;
    logic [2:0]  step_q, step_d;
    logic [2:0]  widx_q, widx_d;
    logic [15:0] status_q, status_d;
    logic        in_frame_q, in_frame_d;
    logic        frame_req_q, frame_req_d;
    logic [15:0] frame_cmd_q, frame_cmd_d;
    logic        sample_valid_q, sample_valid_d;
    logic [1:0]  sample_ch_q, sample_ch_d;
    logic [23:0] sample_data_q, sample_data_d;
    logic        completed_q, completed_d;
    logic        init_error_q, init_error_d;
    logic [1:0]  error_code_q, error_code_d;
    logic [7:0]  overrun_q, overrun_d;

    logic        drdy_pulse;
    logic        init_ok;
    logic        frame_idle;
    logic        done;
    logic [15:0] status_now;

    // [1:0] synchronize the pin, [2] is the edge register
    assign drdy_pulse = drdy_sync_q[2] & ~drdy_sync_q[1];

    always_comb begin
        drdy_sync_d    = {drdy_sync_q[1:0], adc_drdy_n};
        state_d        = state_q;
        spi_reset_d    = spi_reset_q;
        tmr_d          = tmr_q;
        poll_d         = poll_q;
        step_d         = step_q;
        widx_d         = widx_q;
        status_d       = status_q;
        in_frame_d     = in_frame_q;
        frame_req_d    = frame_req_q;
        frame_cmd_d    = frame_cmd_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        completed_d    = completed_q;
        init_error_d   = init_error_q;
        error_code_d   = error_code_q;
        overrun_d      = overrun_q;

        init_ok    = adc_init && (state_q == IDLE || state_q == RUN_WAIT || state_q == ERROR);
        frame_idle = !frame_req_q && !in_frame_q;
        done       = frame_done && in_frame_q;
        // status may arrive in the same cycle it is needed only if word 0 is last
        status_now = (rx_word_valid && widx_q == 3'd0) ? rx_word[23:8] : status_q;

        if (frame_req_q && frame_ack) begin
            frame_req_d = 1'b0;
            in_frame_d  = 1'b1;
            widx_d      = 3'd0;
        end else if (rx_word_valid && widx_q != 3'd7) begin
            widx_d = widx_q + 3'd1;
        end
        if (rx_word_valid && widx_q == 3'd0) status_d = rx_word[23:8];
        if (frame_done) in_frame_d = 1'b0;

        // a pending or in-flight frame cannot absorb another DRDY edge
        if (drdy_pulse && state_q == RUN_READ && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;

        case (state_q)
            IDLE: ;
            HWRST: begin
                if (tmr_q != 32'd0) begin
                    tmr_d = tmr_q - 32'd1;
                end else if (!spi_reset_q) begin
                    spi_reset_d = 1'b1;
                    tmr_d       = WAIT_LD;
                end else begin
                    state_d = POLL;
                    poll_d  = 8'd0;
                end
            end
            POLL: begin
                if (done) begin
                    if (status_now == READY_WORD) begin
                        state_d = CFG;
                        step_d  = 3'd0;
                    end else begin
                        poll_d = poll_q + 8'd1;
                        if (poll_q + 8'd1 == POLL_MAX) begin
                            state_d      = ERROR;
                            init_error_d = 1'b1;
                            error_code_d = 2'd1;
                        end
                    end
                end else if (frame_idle) begin
                    frame_req_d = 1'b1;
                    frame_cmd_d = 16'h0000;
                end
            end
            CFG: begin
                if (done) begin
                    if (step_q != 3'd0 && status_now != cfg_ack(step_q - 3'd1)) begin
                        state_d      = ERROR;
                        init_error_d = 1'b1;
                        error_code_d = 2'd2;
                    end else if (step_q == 3'd6) begin
                        completed_d = 1'b1;
                        state_d     = RUN_WAIT;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end else if (frame_idle) begin
                    frame_req_d = 1'b1;
                    frame_cmd_d = cfg_cmd(step_q);
                end
            end
            RUN_WAIT: begin
                if (drdy_pulse) begin
                    frame_req_d = 1'b1;
                    frame_cmd_d = 16'h0000;
                    state_d     = RUN_READ;
                end
            end
            RUN_READ: begin
                if (rx_word_valid && widx_q != 3'd0 && widx_q <= NCH) begin
                    sample_valid_d = 1'b1;
                    sample_ch_d    = 2'(widx_q - 3'd1);
                    sample_data_d  = rx_word;
                end
                if (done) state_d = RUN_WAIT;
            end
            ERROR: frame_req_d = 1'b0;
            default: state_d = IDLE;
        endcase

        if (init_ok) begin
            state_d      = HWRST;
            spi_reset_d  = 1'b0;
            tmr_d        = LOW_LD;
            frame_req_d  = 1'b0;
            completed_d  = 1'b0;
            init_error_d = 1'b0;
            error_code_d = 2'd0;
            overrun_d    = 8'd0;
        end
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q        <= IDLE;
            drdy_sync_q    <= 3'b111;
            spi_reset_q    <= 1'b1;
            tmr_q          <= 32'd0;
            poll_q         <= 8'd0;
            step_q         <= 3'd0;
            widx_q         <= 3'd0;
            status_q       <= 16'h0000;
            in_frame_q     <= 1'b0;
            frame_req_q    <= 1'b0;
            frame_cmd_q    <= 16'h0000;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 2'd0;
            sample_data_q  <= 24'd0;
            completed_q    <= 1'b0;
            init_error_q   <= 1'b0;
            error_code_q   <= 2'd0;
            overrun_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            drdy_sync_q    <= drdy_sync_d;
            spi_reset_q    <= spi_reset_d;
            tmr_q          <= tmr_d;
            poll_q         <= poll_d;
            step_q         <= step_d;
            widx_q         <= widx_d;
            status_q       <= status_d;
            in_frame_q     <= in_frame_d;
            frame_req_q    <= frame_req_d;
            frame_cmd_q    <= frame_cmd_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            completed_q    <= completed_d;
            init_error_q   <= init_error_d;
            error_code_q   <= error_code_d;
            overrun_q      <= overrun_d;
        end
    end

    assign SPI_RESET          = spi_reset_q;
    assign frame_req          = frame_req_q;
    assign frame_cmd          = frame_cmd_q;
    assign sample_valid       = sample_valid_q;
    assign sample_ch          = sample_ch_q;
    assign sample_data        = sample_data_q;
    assign adc_init_completed = completed_q;
    assign init_error         = init_error_q;
    assign error_code         = error_code_q;
    assign overrun_cnt        = overrun_q;
    assign state              = state_q;

endmodule

// File: tb/tb_ads131_sequencer.sv
// Bench for ads131_sequencer: an ADC/SPI-master model answers each frame with
// the device's response to the previous command, and a scoreboard checks the
// sample stream against the data words the model sent.
module tb_ads131_sequencer;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_init;
    logic        adc_drdy_n;
    logic        SPI_RESET;
    logic        frame_req;
    logic [15:0] frame_cmd;
    logic        frame_ack;
    logic        rx_word_valid;
    logic [23:0] rx_word;
    logic        frame_done;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [23:0] sample_data;
    logic        adc_init_completed;
    logic        init_error;
    logic [1:0]  error_code;
    logic [7:0]  overrun_cnt;
    logic [2:0]  state;

    ads131_sequencer #(
        .NUM_CH(NCH), .RST_LOW_CYC(4), .RST_WAIT_CYC(20), .READY_POLL_MAX(16),
        .CLK1_VAL(8'h02), .CLK2_VAL(8'h25), .ADC_ENA_VAL(8'h0F)
    ) dut (
        .system_clock(clk), .reset(reset), .adc_init(adc_init), .adc_drdy_n(adc_drdy_n),
        .SPI_RESET(SPI_RESET), .frame_req(frame_req), .frame_cmd(frame_cmd),
        .frame_ack(frame_ack), .rx_word_valid(rx_word_valid), .rx_word(rx_word),
        .frame_done(frame_done), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .adc_init_completed(adc_init_completed),
        .init_error(init_error), .error_code(error_code), .overrun_cnt(overrun_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // model configuration, written by the main sequence
    logic [15:0] ready_word  = 16'hFF04;
    bit          corrupt     = 1'b0;
    bit          stream_mode = 1'b0;
    int          ack_mode    = -1;
    int          extra_words = 0;
    logic [15:0] prev_cmd    = 16'h0000;

    logic [15:0] cmd_log[$];
    bit          done_comp[$];
    logic [23:0] data_q[$];
    logic [25:0] exp_q[$];
    int          frame_cnt  = 0;
    int          sample_cnt = 0;

    // device answer to a command, seen in the next frame's status word
    function automatic logic [15:0] resp(input logic [15:0] p);
        if (p == 16'h0000) return ready_word;
        if (p[15:8] >= 8'h4D && p[15:8] <= 8'h4F) begin
            if (corrupt && p == 16'h4E25) return 16'h2E24;
            return p - 16'h2000;
        end
        return p;
    endfunction

    initial begin : spi_model
        logic [15:0] c0;
        logic [15:0] st;
        logic [23:0] wd;
        int          dly, cnt, nw;
        bit          stable;
        frame_ack = 0; rx_word_valid = 0; rx_word = 0; frame_done = 0;
        forever begin
            @(negedge clk);
            if (frame_req && !reset) begin
                c0 = frame_cmd; stable = 1; cnt = 0;
                dly = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
                while (cnt < dly && frame_req) begin
                    @(negedge clk);
                    if (frame_req) stable = stable && (frame_cmd == c0);
                    cnt++;
                end
                if (frame_req) begin
                    frame_ack = 1;
                    @(negedge clk);
                    frame_ack = 0;
                    chk("req_drop", frame_req, 0);
                    chk("cmd_hold", stable, 1);
                    cmd_log.push_back(c0);
                    st = resp(prev_cmd);
                    prev_cmd = c0;
                    nw = NCH + 1 + extra_words;
                    for (int w = 0; w < nw; w++) begin
                        if (stream_mode && data_q.size() > 0) wd = data_q.pop_front();
                        else if (stream_mode || w != 0)       wd = 24'($urandom);
                        else                                  wd = {st, 8'h00};
                        if (stream_mode && w >= 1 && w <= NCH) exp_q.push_back({2'(w - 1), wd});
                        rx_word_valid = 1; rx_word = wd; frame_done = (w == nw - 1);
                        @(negedge clk);
                    end
                    rx_word_valid = 0; frame_done = 0;
                    done_comp.push_back(adc_init_completed);
                    frame_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sample_valid) begin
            if (exp_q.size() == 0) chk("sample_extra", {sample_ch, sample_data}, 0);
            else                   chk("sample", {sample_ch, sample_data}, exp_q.pop_front());
            sample_cnt++;
        end
    end

    task automatic run_init(output int low);
        prev_cmd = 16'h0000;
        cmd_log.delete();
        done_comp.delete();
        adc_init = 1; @(negedge clk); adc_init = 0;
        low = 0;
        while (SPI_RESET == 1'b0 && low < 1000) begin low++; @(negedge clk); end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin @(negedge clk); n++; end
        chk(tag, state, s);
    endtask

    task automatic wait_frames(input int tgt, input int budget, input string tag);
        int n = 0;
        while (frame_cnt < tgt && n < budget) begin @(negedge clk); n++; end
        chk(tag, frame_cnt, tgt);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int n = 0;
        while (!frame_req && n < budget) begin @(negedge clk); n++; end
        chk(tag, frame_req, 1);
    endtask

    initial begin : watchdog
        #800000;
        chk("watchdog", 0, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : main
        logic [15:0] exp_cmds [8];
        int low, f0, s0, lat;
        exp_cmds = '{16'h0000, 16'h0655, 16'h4D02, 16'h4E25, 16'h4F0F, 16'h0033, 16'h0555, 16'h0000};
        reset = 1; adc_init = 0; adc_drdy_n = 1;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_spi_reset", SPI_RESET, 1);
        chk("rst_req", frame_req, 0);
        chk("rst_cmd", frame_cmd, 0);
        chk("rst_sample", {sample_valid, sample_ch, sample_data}, 0);
        chk("rst_flags", {adc_init_completed, init_error, error_code}, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 0;
        @(negedge clk);

        // nominal init
        run_init(low);
        chk("rst_low_cycles", low, 4);
        wait_state(3'd4, 3000, "init_run_wait");
        chk("init_frames", cmd_log.size(), 8);
        if (cmd_log.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("cmd%0d", i), cmd_log[i], exp_cmds[i]);
            chk("comp_after7", done_comp[6], 0);
            chk("comp_after8", done_comp[7], 1);
        end
        chk("init_completed", adc_init_completed, 1);

        // streaming with boundary values
        stream_mode = 1;
        data_q.push_back(24'h000000); data_q.push_back(24'h7FFFFF);
        data_q.push_back(24'h800000); data_q.push_back(24'h000001);
        data_q.push_back(24'hFFFFFF);
        f0 = frame_cnt; s0 = sample_cnt;
        adc_drdy_n = 0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1; lat++;
            if (frame_req) break;
        end
        chk("drdy_latency_ok", (lat >= 3 && lat <= 4), 1);
        @(negedge clk);
        wait_frames(f0 + 1, 200, "stream_frame");
        repeat (2) @(negedge clk);
        chk("stream_samples", sample_cnt - s0, NCH);
        adc_drdy_n = 1;
        repeat (4) @(negedge clk);

        // random frames, one carrying extra words
        for (int i = 0; i < 6; i++) begin
            extra_words = (i == 2) ? 2 : 0;
            f0 = frame_cnt; s0 = sample_cnt;
            adc_drdy_n = 0;
            wait_frames(f0 + 1, 200, "rand_frame");
            repeat (2) @(negedge clk);
            chk($sformatf("rand_samples%0d", i), sample_cnt - s0, NCH);
            adc_drdy_n = 1;
            repeat (4) @(negedge clk);
        end
        extra_words = 0;
        chk("exp_drained", exp_q.size(), 0);

        // single overrun during a frame
        ack_mode = 8;
        f0 = frame_cnt;
        adc_drdy_n = 0;
        wait_req(20, "ovr_req");
        adc_drdy_n = 1;
        repeat (3) @(negedge clk);
        adc_drdy_n = 0;
        wait_frames(f0 + 1, 200, "ovr_frame");
        repeat (20) @(negedge clk);
        chk("ovr_one", overrun_cnt, 1);
        chk("ovr_no_extra_frame", frame_cnt, f0 + 1);
        adc_drdy_n = 1;
        repeat (4) @(negedge clk);

        // saturation: many edges while a frame is held pending
        ack_mode = 2000;
        f0 = frame_cnt;
        adc_drdy_n = 0;
        wait_req(20, "sat_req");
        for (int i = 0; i < 300; i++) begin
            adc_drdy_n = 1; repeat (3) @(negedge clk);
            adc_drdy_n = 0; repeat (3) @(negedge clk);
        end
        ack_mode = -1;
        wait_frames(f0 + 1, 3000, "sat_frame");
        repeat (4) @(negedge clk);
        chk("ovr_sat", overrun_cnt, 255);
        adc_drdy_n = 1;
        repeat (4) @(negedge clk);

        // READY never returned
        stream_mode = 0;
        ready_word = 16'h0000;
        f0 = frame_cnt;
        run_init(low);
        chk("ovr_cleared", overrun_cnt, 0);
        chk("completed_cleared", adc_init_completed, 0);
        wait_state(3'd6, 3000, "timeout_error_state");
        chk("poll_frames", frame_cnt - f0, 16);
        chk("timeout_flags", {init_error, error_code}, 3'b101);
        f0 = frame_cnt;
        repeat (50) @(negedge clk);
        chk("error_no_frames", frame_cnt, f0);
        chk("error_no_req", frame_req, 0);

        // corrupted CLK2 ack, then recovery
        ready_word = 16'hFF04;
        corrupt = 1;
        f0 = frame_cnt;
        run_init(low);
        chk("err_cleared", {init_error, error_code}, 0);
        wait_state(3'd6, 3000, "ack_error_state");
        chk("ack_err_code", error_code, 2);
        chk("ack_err_completed", adc_init_completed, 0);
        chk("ack_err_frames", frame_cnt - f0, 5);
        corrupt = 0;
        run_init(low);
        chk("recover_rst_low", low, 4);
        wait_state(3'd4, 3000, "recover_run_wait");
        chk("recover_flags", {adc_init_completed, init_error, error_code}, 4'b1000);

        // slow ack in CFG, then reset while a request is pending
        ack_mode = 10;
        f0 = frame_cnt;
        run_init(low);
        begin
            int n = 0;
            while (!(state == 3'd3 && frame_req && frame_cnt >= f0 + 3) && n < 3000) begin
                @(negedge clk); n++;
            end
        end
        chk("midcfg_reached", {state, frame_req}, {3'd3, 1'b1});
        reset = 1;
        @(negedge clk);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_req", frame_req, 0);
        chk("mid_rst_cmd", frame_cmd, 0);
        chk("mid_rst_spi", SPI_RESET, 1);
        chk("mid_rst_flags", {adc_init_completed, init_error, error_code, overrun_cnt}, 0);
        chk("mid_rst_sample", {sample_valid, sample_ch, sample_data}, 0);
        reset = 0;
        ack_mode = -1;
        repeat (3) @(negedge clk);
        run_init(low);
        wait_state(3'd4, 3000, "final_run_wait");
        chk("final_completed", adc_init_completed, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
